// File: rtl/registro_universal_n.sv
// Parametrised N-bit universal shift register: shift, rotate, parallel load and hold,
// plus a saturating serial-fill counter with FULL/DONE flags. Optional macro ARITH_SHIFT_EN.
module registro_universal_n #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic [1:0]       MODO,
    input  logic [AW-1:0]    AMT,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic [AW:0]      CNT,
    output logic             FULL,
    output logic             DONE
);

    localparam logic [AW:0]   L_WIDTH_C = (AW+1)'(WIDTH);
    localparam logic [AW+1:0] L_WIDTH_S = (AW+2)'(WIDTH);

    localparam logic [1:0] L_MODO_SHIFT  = 2'b00;
    localparam logic [1:0] L_MODO_ROTATE = 2'b01;
    localparam logic [1:0] L_MODO_LOAD   = 2'b10;
    localparam logic [1:0] L_MODO_ARITH  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [AW:0]      r_cnt;
    logic             r_full;
    logic             r_done;

    logic [AW:0]      w_k;
    logic [AW:0]      w_kM1;
    logic             w_kZero;
    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_loMask;
    logic [WIDTH-1:0] w_hiMask;
    logic [WIDTH-1:0] w_leftSel;
    logic [WIDTH-1:0] w_rightSel;
    logic             w_leftOut;
    logic             w_rightOut;
    logic [WIDTH-1:0] w_shlQ;
    logic [WIDTH-1:0] w_shrQ;
    logic [WIDTH-1:0] w_rolQ;
    logic [WIDTH-1:0] w_rorQ;
    logic [AW+1:0]    w_sum;
    logic [AW:0]      w_cntSat;
    logic             w_countStep;

    logic [WIDTH-1:0] w_qNext;
    logic             w_soutNext;
    logic [AW:0]      w_cntNext;
    logic             w_fullNext;
    logic             w_doneNext;

`ifdef ARITH_SHIFT_EN
    logic [WIDTH-1:0] w_asrQ;
`endif

    // AMT beyond WIDTH-1 (non power-of-two widths) wraps around
    assign w_k     = {1'b0, AMT} % L_WIDTH_C;
    assign w_kM1   = w_k - (AW+1)'(1);
    assign w_kZero = (w_k == '0);

    assign w_ones   = '1;
    assign w_loMask = ~(w_ones << w_k);
    assign w_hiMask = ~(w_ones >> w_k);

    // One-hot selectors for the last bit to cross each boundary: Q[WIDTH-k] and Q[k-1]
    assign w_leftSel  = {1'b1, {(WIDTH-1){1'b0}}} >> w_kM1;
    assign w_rightSel = {{(WIDTH-1){1'b0}}, 1'b1} << w_kM1;
    assign w_leftOut  = |(r_q & w_leftSel);
    assign w_rightOut = |(r_q & w_rightSel);

    assign w_shlQ = (r_q << w_k) | (w_loMask & {WIDTH{S_IN}});
    assign w_shrQ = (r_q >> w_k) | (w_hiMask & {WIDTH{S_IN}});
    assign w_rolQ = (r_q << w_k) | (r_q >> (L_WIDTH_C - w_k));
    assign w_rorQ = (r_q >> w_k) | (r_q << (L_WIDTH_C - w_k));

`ifdef ARITH_SHIFT_EN
    assign w_asrQ = (r_q >> w_k) | (w_hiMask & {WIDTH{r_q[WIDTH-1]}});
`endif

    assign w_sum    = {1'b0, r_cnt} + {1'b0, w_k};
    assign w_cntSat = (w_sum >= L_WIDTH_S) ? L_WIDTH_C : w_sum[AW:0];

    always_comb begin
        w_qNext     = r_q;
        w_soutNext  = r_sout;
        w_cntNext   = r_cnt;
        w_fullNext  = r_full;
        w_doneNext  = 1'b0;
        w_countStep = 1'b0;
        if (ENB) begin
            case (MODO)
                L_MODO_SHIFT: begin
                    if (!w_kZero) begin
                        w_qNext     = DIR ? w_shrQ : w_shlQ;
                        w_soutNext  = DIR ? w_rightOut : w_leftOut;
                        w_countStep = 1'b1;
                    end
                end
                L_MODO_ROTATE: begin
                    if (!w_kZero) begin
                        w_qNext    = DIR ? w_rorQ : w_rolQ;
                        w_soutNext = DIR ? w_rightOut : w_leftOut;
                    end
                end
                L_MODO_LOAD: begin
                    w_qNext    = D;
                    w_cntNext  = '0;
                    w_fullNext = 1'b0;
                end
                L_MODO_ARITH: begin
`ifdef ARITH_SHIFT_EN
                    if (!w_kZero) begin
                        w_qNext     = w_asrQ;
                        w_soutNext  = w_rightOut;
                        w_countStep = 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
            // DONE fires only on the transition into saturation; FULL then stays sticky
            if (w_countStep) begin
                w_cntNext = w_cntSat;
                if ((r_cnt != L_WIDTH_C) && (w_cntSat == L_WIDTH_C)) begin
                    w_doneNext = 1'b1;
                    w_fullNext = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_qNext;
            r_sout <= w_soutNext;
            r_cnt  <= w_cntNext;
            r_full <= w_fullNext;
            r_done <= w_doneNext;
        end
    end

    assign Q     = r_q;
    assign S_OUT = r_sout;
    assign CNT   = r_cnt;
    assign FULL  = r_full;
    assign DONE  = r_done;

endmodule
